scancode_display_ctrl: RTL

- Sequences the scancode-to-seven-segment decoders for a multi-digit typed-text display.
- Takes raw PS/2 scancode bytes from the keyboard receiver and strips break (F0) and extended (E0) sequences.
- Maintains a shift buffer of displayed make codes and handles backspace and escape.
- Drives one 7-bit code plus one flag bit to each decoder instance, with digit 0 being the rightmost, newest character.

---
 rtl/scancode_display_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/scancode_display_ctrl.sv
// scancode_display_ctrl
//
// Turns the raw PS/2 scancode byte stream into the contents of a
// multi-digit typed-text display. It drives one 7-bit code and one enable
// flag to each downstream scancode-to-seven-segment decoder.
//
// Break sequences (F0 xx) and extended sequences (E0 xx, E0 F0 xx) are
// stripped. Plain make codes are shifted in at digit 0, which is the
// rightmost and newest character. Esc (0x76) clears the display and
// Backspace (0x66) removes the newest character. A digit is blanked by
// giving it the code 7'h7F.
//
// Parameters:
//   NUM_DIGITS      number of digits / decoder instances driven (1..8)
//   TIMEOUT_CYCLES  idle cycles after an F0/E0 prefix before that
//                   sequence is abandoned (>= 2)
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   code_in     in   [7:0] scancode byte from the PS/2 receiver
//   code_valid  in   single-cycle strobe that qualifies code_in
//   disp_code   out  [7*NUM_DIGITS-1:0] per-digit code; digit i is in
//                    bits [7i+6:7i]
//   disp_flag   out  [NUM_DIGITS-1:0] per-digit decoder enable flag
//   char_count  out  [3:0] number of non-blank digits
//   update      out  one-cycle pulse in the cycle after the buffer changes
//
// Optional feature (compile-time macro SCANCODE_REPEAT_FILTER_EN):
//   When defined, a make code equal to the last displayed make code is
//   dropped. This suppresses typematic repeat. Releasing that key
//   (F0 xx) re-arms it.
//   When undefined, every make code is displayed.

module scancode_display_ctrl #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              code_in,
  input  logic                    code_valid,
  output logic [7*NUM_DIGITS-1:0] disp_code,
  output logic [NUM_DIGITS-1:0]   disp_flag,
  output logic [3:0]              char_count,
  output logic                    update
);

  // Scancode constants.
  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_ESC = 8'h76;
  localparam logic [7:0] CODE_BKSP = 8'h66;
  localparam logic [6:0] BLANK = 7'h7F;

  // FSM states.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BRK     = 2'd1;
  localparam logic [1:0] ST_EXT     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] COUNT_MAX = 4'(NUM_DIGITS);

  logic [1:0]                        state_q, state_d;
  logic [TMR_W-1:0]                  tmr_q, tmr_d;
  logic [NUM_DIGITS-1:0][6:0]        digit_q, digit_d;
  logic [3:0]                        count_q, count_d;
  logic                              update_q, update_d;
  logic [NUM_DIGITS-1:0]             flag_q;
`ifdef SCANCODE_REPEAT_FILTER_EN
  logic [7:0]                        last_make_q, last_make_d;
`endif

  // Combined next-state logic: prefix FSM, timeout counter, digit buffer.
  always_comb begin
    logic do_push;
    do_push  = 1'b0;
    state_d  = state_q;
    tmr_d    = tmr_q;
    digit_d  = digit_q;
    count_d  = count_q;
    update_d = 1'b0;
`ifdef SCANCODE_REPEAT_FILTER_EN
    last_make_d = last_make_q;
`endif

    if (code_valid) begin
      // A byte always wins over a timeout that would fire in the same cycle.
      tmr_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (code_in == CODE_BRK) begin
            state_d = ST_BRK;
          end else if (code_in == CODE_EXT) begin
            state_d = ST_EXT;
          end else if (code_in == CODE_ESC) begin
            digit_d  = {NUM_DIGITS{BLANK}};
            count_d  = '0;
            update_d = 1'b1;
          end else if (code_in == CODE_BKSP) begin
            for (int i = 0; i < NUM_DIGITS - 1; i++) begin
              digit_d[i] = digit_q[i+1];
            end
            digit_d[NUM_DIGITS-1] = BLANK;
            count_d  = (count_q == 4'd0) ? count_q : count_q - 4'd1;
            update_d = 1'b1;
          end else if (!code_in[7]) begin
`ifdef SCANCODE_REPEAT_FILTER_EN
            if (code_in != last_make_q) begin
              do_push     = 1'b1;
              last_make_d = code_in;
            end
`else
            do_push = 1'b1;
`endif
          end
          // Any other code with bit 7 set is ignored without an update.
        end
        ST_BRK: begin
          state_d = ST_IDLE;
`ifdef SCANCODE_REPEAT_FILTER_EN
          // Releasing the filtered key lets the next press through again.
          if (code_in == last_make_q) begin
            last_make_d = 8'h00;
          end
`endif
        end
        ST_EXT: begin
          state_d = (code_in == CODE_BRK) ? ST_EXT_BRK : ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmr_q == TMR_LAST) begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end else begin
      tmr_d = '0;
    end

    // Shift a make code in at digit 0. The top digit falls off.
    if (do_push) begin
      digit_d[0] = code_in[6:0];
      for (int i = 1; i < NUM_DIGITS; i++) begin
        digit_d[i] = digit_q[i-1];
      end
      count_d  = (count_q == COUNT_MAX) ? count_q : count_q + 4'd1;
      update_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      digit_q  <= {NUM_DIGITS{BLANK}};
      count_q  <= '0;
      update_q <= 1'b0;
      flag_q   <= '1;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      digit_q  <= digit_d;
      count_q  <= count_d;
      update_q <= update_d;
      // Decoders stay enabled. Blanking is done only through the 7'h7F code.
      flag_q   <= '1;
    end
  end

`ifdef SCANCODE_REPEAT_FILTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_make_q <= 8'h00;
    end else begin
      last_make_q <= last_make_d;
    end
  end
`endif

  assign disp_code  = digit_q;
  assign disp_flag  = flag_q;
  assign char_count = count_q;
  assign update     = update_q;

endmodule
